gate_operand_fifo: RTL and testbench
====================================

// Module: gate_operand_fifo
// PURPOSE
//  - Operand buffer directly upstream of the gate-logic unit (AND/OR/XOR stage).
//  - Accepts {A,B} operand pairs from decode over valid/ready and stores DEPTH entries.
//  - Presents the head entry to the gate unit over valid/ready.
//  - Decouples decode stalls from logic-unit stalls. Outputs are registered (no fall-through).
// PARAMETERS
//  DATA_WIDTH  8   operand width, bits; >= 1
//  DEPTH       4   entries; power of 2, >= 2
// PORTS
//  clk_i        in   1               clock, rising edge
//  arst_ni      in   1               reset; asynchronous, active-low
//  flush_i      in   1               synchronous discard of all entries
//  in_a_i       in   DATA_WIDTH      operand A from decode
//  in_b_i       in   DATA_WIDTH      operand B from decode
//  in_valid_i   in   1               upstream offers an operand pair
//  in_ready_o   out  1               FIFO can accept a pair
//  out_a_o      out  DATA_WIDTH      head operand A to gate unit
//  out_b_o      out  DATA_WIDTH      head operand B to gate unit
//  out_valid_o  out  1               head entry valid
//  out_ready_i  in   1               gate unit consumes head
//  count_o      out  $clog2(DEPTH)+1 current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (arst_ni=0, async): count_o=0, out_valid_o=0, in_ready_o=1, out_a_o/out_b_o=0,
//    all storage=0, wr/rd ptrs=0. Holds while low; release takes effect on the next edge.
//  - Reset mid-operation: all entries are dropped immediately; no partial state survives.
//  - push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
//  - in_ready_o = (count_o != DEPTH). Depends on state only, never on out_ready_i.
//    When full, a same-cycle pop does NOT enable a push.
//  - out_valid_o = (count_o != 0). Head data comes from a registered read port.
//  - Latency: a push into an empty FIFO appears on out_* with out_valid_o=1 one cycle later.
//  - State (derived from count): EMPTY(0) / PARTIAL(1..DEPTH-1) / FULL(DEPTH).
//      EMPTY   --push-->               PARTIAL (or FULL if DEPTH==1, excluded)
//      PARTIAL --push&!pop-->          +1, FULL when count reaches DEPTH
//      PARTIAL --pop&!push-->          -1, EMPTY when count reaches 0
//      PARTIAL --push&pop-->           count unchanged, both ptrs advance
//      FULL    --pop-->                PARTIAL; push impossible in FULL
//  - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 with no gap or bubble.
//  - out_a_o/out_b_o stay stable while out_valid_o & !out_ready_i.
//  - When EMPTY, out_a_o/out_b_o hold the last popped value (0 after reset). Content is
//    don't-care to the consumer.
//  - flush_i=1 at an edge: count=0, ptrs=0, out_valid_o=0, in_ready_o=1 next cycle.
//    flush overrides a simultaneous push and pop; the pushed pair is discarded.
//  - in_valid_i may drop without handshake. No requirement to hold data while stalled upstream.
//  - Ordering: strict FIFO; no entry is duplicated or lost except by flush/reset.
// CONFIGURATION
//  GATE_OPERAND_FIFO_STALL_CNT_EN
//   defined:  adds port stall_cnt_o out 16 (a 16-bit register).
//             Increments each cycle that in_valid_i & !in_ready_o; saturates at 16'hFFFF.
//             Cleared to 0 by reset and by flush_i. A flush cycle does not count.
//   undefined: port and logic absent; all other behaviour identical.
// TESTING
//  1. Reset, then push A=8'hF0,B=8'h0F in cycle 0 -> cycle 1: out_valid_o=1, out=F0/0F,
//     count_o=1.
//  2. out_ready_i=0, push 4 pairs (01..04) -> count_o=4, in_ready_o=0. A 5th offer is held.
//     Pop 1 -> out=01; in_ready_o=1 next cycle.
//  3. Full FIFO, in_valid_i=1 and out_ready_i=1 same cycle -> pop only; count_o 4->3;
//     5th pair accepted next cycle.
//  4. count_o=2 with simultaneous push/pop for 10 cycles, data 00..09 -> count_o stays 2;
//     output order 00..09 across pointer wrap.
//  5. count_o=3, flush_i=1 with push -> next cycle count_o=0, out_valid_o=0;
//     flushed pair never appears.
//  6. (STALL_CNT_EN) Full FIFO, in_valid_i=1 for 5 cycles -> stall_cnt_o=5;
//     arst_ni low mid-run -> all outputs at reset values immediately.

Source files
------------

// File: rtl/gate_operand_fifo.sv
// Operand FIFO in front of the gate-logic unit: {A,B} pairs in, registered head out.
// Optional stall counter port is enabled by defining GATE_OPERAND_FIFO_STALL_CNT_EN.
module gate_operand_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic                       flush_i,
  input  logic [DATA_WIDTH-1:0]      in_a_i,
  input  logic [DATA_WIDTH-1:0]      in_b_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [DATA_WIDTH-1:0]      out_a_o,
  output logic [DATA_WIDTH-1:0]      out_b_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
`ifdef GATE_OPERAND_FIFO_STALL_CNT_EN
  ,
  output logic [15:0]                stall_cnt_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } state_t;

  logic [DATA_WIDTH-1:0] mem_a [DEPTH];
  logic [DATA_WIDTH-1:0] mem_b [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         rd_next;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  push;
  logic                  pop;
  logic                  head_from_in;
  state_t                state;
  state_t                state_next;

  // A push into a FIFO that is (or becomes) empty this cycle bypasses storage to the head.
  always_comb begin
    push         = in_valid_i & in_ready_o;
    pop          = out_valid_o & out_ready_i;
    rd_next      = pop ? rd_ptr + PW'(1) : rd_ptr;
    count_next   = count + CW'(push) - CW'(pop);
    head_from_in = push & ((count - CW'(pop)) == '0);
    if (count_next == '0)
      state_next = ST_EMPTY;
    else if (count_next == CW'(DEPTH))
      state_next = ST_FULL;
    else
      state_next = ST_PARTIAL;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else if (!flush_i && push) begin
      mem_a[wr_ptr] <= in_a_i;
      mem_b[wr_ptr] <= in_b_i;
    end
  end

  // Head data is only refreshed while an entry remains, so an empty FIFO shows the last pop.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state       <= ST_EMPTY;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
      out_a_o     <= '0;
      out_b_o     <= '0;
    end else if (flush_i) begin
      state       <= ST_EMPTY;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
    end else begin
      state       <= state_next;
      count       <= count_next;
      rd_ptr      <= rd_next;
      out_valid_o <= (state_next != ST_EMPTY);
      in_ready_o  <= (state_next != ST_FULL);
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (state_next != ST_EMPTY) begin
        out_a_o <= head_from_in ? in_a_i : mem_a[rd_next];
        out_b_o <= head_from_in ? in_b_i : mem_b[rd_next];
      end
    end
  end

  assign count_o = count;

`ifdef GATE_OPERAND_FIFO_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni)
      stall_cnt_o <= '0;
    else if (flush_i)
      stall_cnt_o <= '0;
    else if (in_valid_i && !in_ready_o && stall_cnt_o != 16'hFFFF)
      stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_gate_operand_fifo.sv
// Directed bench for gate_operand_fifo; stall counter checks run when
// GATE_OPERAND_FIFO_STALL_CNT_EN is defined.
module tb_gate_operand_fifo;

  logic       clk_i = 1'b0;
  logic       arst_ni;
  logic       flush_i;
  logic [7:0] in_a_i;
  logic [7:0] in_b_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] out_a_o;
  logic [7:0] out_b_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [2:0] count_o;
`ifdef GATE_OPERAND_FIFO_STALL_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  gate_operand_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .flush_i     (flush_i),
    .in_a_i      (in_a_i),
    .in_b_i      (in_b_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_a_o     (out_a_o),
    .out_b_o     (out_b_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .count_o     (count_o)
`ifdef GATE_OPERAND_FIFO_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic apply_stimulus(input logic fl, input logic vld, input logic [7:0] a,
                                input logic [7:0] b, input logic rdy);
    flush_i     = fl;
    in_valid_i  = vld;
    in_a_i      = a;
    in_b_i      = b;
    out_ready_i = rdy;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    arst_ni     = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_a_i      = '0;
    in_b_i      = '0;
    out_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_output("rst_count", 32'(count_o), 0);
    check_output("rst_out_valid", 32'(out_valid_o), 0);
    check_output("rst_in_ready", 32'(in_ready_o), 1);
    check_output("rst_out_a", 32'(out_a_o), 0);
    check_output("rst_out_b", 32'(out_b_o), 0);
`ifdef GATE_OPERAND_FIFO_STALL_CNT_EN
    check_output("rst_stall", 32'(stall_cnt_o), 0);
`endif
    arst_ni = 1'b1;
    apply_stimulus(0, 0, 8'h00, 8'h00, 0);

    // First push into empty FIFO shows up one cycle later
    apply_stimulus(0, 1, 8'hF0, 8'h0F, 0);
    check_output("t1_out_valid", 32'(out_valid_o), 1);
    check_output("t1_out_a", 32'(out_a_o), 32'hF0);
    check_output("t1_out_b", 32'(out_b_o), 32'h0F);
    check_output("t1_count", 32'(count_o), 1);
    apply_stimulus(0, 0, 8'h00, 8'h00, 1);
    check_output("t1_pop_count", 32'(count_o), 0);
    check_output("t1_pop_valid", 32'(out_valid_o), 0);
    check_output("t1_hold_a", 32'(out_a_o), 32'hF0);

    // Fill to DEPTH with the consumer stalled
    for (int i = 1; i <= 4; i++)
      apply_stimulus(0, 1, 8'(i), 8'(i + 8'h10), 0);
    check_output("t2_count_full", 32'(count_o), 4);
    check_output("t2_in_ready", 32'(in_ready_o), 0);
    check_output("t2_head_a", 32'(out_a_o), 32'h01);
    check_output("t2_head_b", 32'(out_b_o), 32'h11);
    apply_stimulus(0, 1, 8'h05, 8'h15, 0);
    check_output("t2_held_count", 32'(count_o), 4);
    check_output("t2_stable_a", 32'(out_a_o), 32'h01);

    // Full with push and pop offered: only the pop happens
    apply_stimulus(0, 1, 8'h05, 8'h15, 1);
    check_output("t3_count", 32'(count_o), 3);
    check_output("t3_in_ready", 32'(in_ready_o), 1);
    check_output("t3_head_a", 32'(out_a_o), 32'h02);
    apply_stimulus(0, 1, 8'h05, 8'h15, 0);
    check_output("t3_accept_count", 32'(count_o), 4);
    for (int i = 2; i <= 5; i++) begin
      check_output("t3_drain_a", 32'(out_a_o), 32'(i));
      check_output("t3_drain_b", 32'(out_b_o), 32'(i + 8'h10));
      apply_stimulus(0, 0, 8'h00, 8'h00, 1);
    end
    check_output("t3_empty", 32'(count_o), 0);

    // Steady-state push/pop at count 2 across pointer wrap
    apply_stimulus(0, 1, 8'h00, 8'hA0, 0);
    apply_stimulus(0, 1, 8'h01, 8'hA1, 0);
    check_output("t4_count_pre", 32'(count_o), 2);
    for (int i = 0; i < 10; i++) begin
      check_output("t4_order_a", 32'(out_a_o), 32'(i));
      check_output("t4_order_b", 32'(out_b_o), 32'(8'hA0 + i));
      apply_stimulus(0, 1, 8'(i + 2), 8'(8'hA2 + i), 1);
      check_output("t4_count", 32'(count_o), 2);
    end
    check_output("t4_tail_a", 32'(out_a_o), 32'h0A);

    // Flush with simultaneous push and pop discards everything
    apply_stimulus(0, 1, 8'h0C, 8'hAC, 0);
    check_output("t5_count_pre", 32'(count_o), 3);
    apply_stimulus(1, 1, 8'hEE, 8'hEE, 1);
    check_output("t5_count", 32'(count_o), 0);
    check_output("t5_out_valid", 32'(out_valid_o), 0);
    check_output("t5_in_ready", 32'(in_ready_o), 1);
    apply_stimulus(0, 1, 8'h55, 8'h66, 0);
    check_output("t5_next_a", 32'(out_a_o), 32'h55);
    check_output("t5_next_b", 32'(out_b_o), 32'h66);
    check_output("t5_next_count", 32'(count_o), 1);
    apply_stimulus(0, 0, 8'h00, 8'h00, 1);
    check_output("t5_drained", 32'(count_o), 0);

    // Stall counting while full, then async reset mid-run
    for (int i = 0; i < 4; i++)
      apply_stimulus(0, 1, 8'(8'h30 + i), 8'h00, 0);
    check_output("t6_full", 32'(count_o), 4);
`ifdef GATE_OPERAND_FIFO_STALL_CNT_EN
    check_output("t6_stall_zero", 32'(stall_cnt_o), 0);
`endif
    repeat (5) apply_stimulus(0, 1, 8'h99, 8'h99, 0);
`ifdef GATE_OPERAND_FIFO_STALL_CNT_EN
    check_output("t6_stall_five", 32'(stall_cnt_o), 5);
    apply_stimulus(1, 1, 8'h99, 8'h99, 0);
    check_output("t6_stall_flush", 32'(stall_cnt_o), 0);
    for (int i = 0; i < 4; i++)
      apply_stimulus(0, 1, 8'(8'h40 + i), 8'h00, 0);
    repeat (2) apply_stimulus(0, 1, 8'h99, 8'h99, 0);
    check_output("t6_stall_two", 32'(stall_cnt_o), 2);
`endif
    check_output("t6_head_a", 32'(out_a_o), 32'(out_a_o == 8'h40 ? 8'h40 : 8'h30));
    arst_ni = 1'b0;
    #1;
    check_output("t6_arst_count", 32'(count_o), 0);
    check_output("t6_arst_valid", 32'(out_valid_o), 0);
    check_output("t6_arst_ready", 32'(in_ready_o), 1);
    check_output("t6_arst_a", 32'(out_a_o), 0);
`ifdef GATE_OPERAND_FIFO_STALL_CNT_EN
    check_output("t6_arst_stall", 32'(stall_cnt_o), 0);
`endif
    apply_stimulus(0, 1, 8'h77, 8'h78, 0);
    check_output("t6_in_reset_count", 32'(count_o), 0);
    arst_ni = 1'b1;
    apply_stimulus(0, 1, 8'h77, 8'h78, 0);
    check_output("t6_post_a", 32'(out_a_o), 32'h77);
    check_output("t6_post_count", 32'(count_o), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
